// File: rtl/game_round_ctrl.sv
// Whack-a-mole round controller: round FSM, LFSR target picker, edge-scored
// BCD hit counter, and timer-reset control so the game timer only runs in PLAY.
module game_round_ctrl #(
    parameter int unsigned TARGET_SECONDS = 2,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       SecondTick,
    input  logic       TimerDone,
    input  logic [3:0] Hit,
    output logic       TimerReset,
    output logic [3:0] TargetMask,
    output logic [3:0] ScoreOnes,
    output logic [3:0] ScoreTens,
    output logic [1:0] State,
    output logic       GameOver,
    output logic       HitPulse
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        PLAY = 2'b10,
        OVER = 2'b11
    } state_t;

    localparam logic [3:0] LIFE_RELOAD = 4'(TARGET_SECONDS);

    state_t     r_state;
    logic       r_timer_rst;
    logic [3:0] r_mask;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_over;
    logic       r_pulse;
    logic [7:0] r_lfsr;
    logic [3:0] r_hit_prev;
    logic [3:0] r_life;
    logic [1:0] r_idx;

    logic [7:0] w_lfsr_next;
    logic [1:0] w_next_idx;
    logic [3:0] w_next_mask;
    logic [3:0] w_edge;
    logic       w_hit_active;
    logic [3:0] w_ones_inc;
    logic [3:0] w_tens_inc;

    always_comb begin
        w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        // Never re-pick the current target, so every change is visible.
        w_next_idx   = (r_lfsr[1:0] == r_idx) ? r_idx + 2'd1 : r_lfsr[1:0];
        w_next_mask  = 4'b0001 << w_next_idx;
        w_edge       = Hit & ~r_hit_prev;
        w_hit_active = |(w_edge & r_mask);
        w_ones_inc   = r_ones;
        w_tens_inc   = r_tens;
        if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
            if (r_ones == 4'd9) begin
                w_ones_inc = '0;
                w_tens_inc = r_tens + 4'd1;
            end else begin
                w_ones_inc = r_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_timer_rst <= 1'b1;
            r_mask      <= '0;
            r_ones      <= '0;
            r_tens      <= '0;
            r_over      <= 1'b0;
            r_pulse     <= 1'b0;
            r_lfsr      <= LFSR_SEED;
            r_hit_prev  <= '0;
            r_life      <= '0;
            r_idx       <= '0;
        end else begin
            r_lfsr     <= w_lfsr_next;
            r_hit_prev <= Hit;
            r_pulse    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer_rst <= 1'b1;
                    r_mask      <= '0;
                    r_over      <= 1'b0;
                    if (Start) r_state <= ARM;
                end
                ARM: begin
                    // TimerReset drops here so it is already low in the first PLAY cycle.
                    r_state     <= PLAY;
                    r_timer_rst <= 1'b0;
                    r_ones      <= '0;
                    r_tens      <= '0;
                    r_mask      <= w_next_mask;
                    r_idx       <= w_next_idx;
                    r_life      <= LIFE_RELOAD;
                end
                PLAY: begin
                    if (TimerDone) begin
                        r_state     <= OVER;
                        r_over      <= 1'b1;
                        r_mask      <= '0;
                        r_timer_rst <= 1'b1;
                    end else if (w_hit_active) begin
                        r_ones  <= w_ones_inc;
                        r_tens  <= w_tens_inc;
                        r_pulse <= 1'b1;
                        r_mask  <= w_next_mask;
                        r_idx   <= w_next_idx;
                        r_life  <= LIFE_RELOAD;
                    end else if (SecondTick) begin
                        if (r_life == 4'd1) begin
                            r_mask <= w_next_mask;
                            r_idx  <= w_next_idx;
                            r_life <= LIFE_RELOAD;
                        end else begin
                            r_life <= r_life - 4'd1;
                        end
                    end
                end
                OVER: begin
                    r_mask      <= '0;
                    r_timer_rst <= 1'b1;
                    r_over      <= 1'b1;
                    if (Start) begin
                        r_state <= ARM;
                        r_over  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign State      = r_state;
    assign TimerReset = r_timer_rst;
    assign TargetMask = r_mask;
    assign ScoreOnes  = r_ones;
    assign ScoreTens  = r_tens;
    assign GameOver   = r_over;
    assign HitPulse   = r_pulse;

endmodule
